// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between two valid/ready requesters.
// The unit returns a registered result, which is held until the consumer takes it.
module addsub_arbiter #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [data_width-1:0] req0_a,
  input  logic [data_width-1:0] req0_b,
  input  logic [3:0]            req0_func,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [data_width-1:0] req1_a,
  input  logic [data_width-1:0] req1_b,
  input  logic [3:0]            req1_func,
  output logic                  req1_ready,
  output logic                  res_valid,
  output logic [data_width-1:0] res_data,
  output logic                  res_overflow,
  output logic                  res_id,
  input  logic                  res_ready
);

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam int         MSB      = data_width - 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic                  grant_any;
  logic                  grant_id;
  logic                  transfer;
  logic [data_width-1:0] op_a;
  logic [data_width-1:0] op_b;
  logic [3:0]            op_func;
  logic                  op_id;
  logic                  is_add;
  logic [data_width-1:0] alu_value;
  logic                  alu_overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset_n && (state == IDLE) && grant_any) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  assign transfer = req0_ready | req1_ready;

  // Every code other than FUNC_ADD subtracts.
  always_comb begin
    is_add    = (op_func == FUNC_ADD);
    alu_value = is_add ? (op_a + op_b) : (op_a - op_b);
    if (is_add) begin
      alu_overflow = (op_a[MSB] == op_b[MSB]) && (alu_value[MSB] != op_a[MSB]);
    end else begin
      alu_overflow = (op_a[MSB] != op_b[MSB]) && (alu_value[MSB] != op_a[MSB]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_func      <= '0;
      op_id        <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_id       <= 1'b0;
    end else begin
      if (transfer) begin
        op_a       <= grant_id ? req1_a : req0_a;
        op_b       <= grant_id ? req1_b : req0_b;
        op_func    <= grant_id ? req1_func : req0_func;
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        res_data     <= alu_value;
        res_overflow <= alu_overflow;
        res_id       <= op_id;
        res_valid    <= 1'b1;
      end
      if ((state == DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: accepted operations are modelled with plain
// integer arithmetic and queued; a monitor compares them against the result port.
module tb_addsub_arbiter;

  localparam int         W        = 16;
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    logic         id;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [3:0]   req0_func = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [3:0]   req1_func = '0;
  logic         req1_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_overflow;
  logic         res_id;
  logic         res_ready = 1'b1;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   model_idle = 1'b1;
  bit   model_last = 1'b1;
  bit   acc0 = 1'b0;
  bit   acc1 = 1'b0;
  logic rst_at_edge = 1'b1;

  addsub_arbiter #(.data_width(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow), .res_id(res_id),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact signed result out of range means overflow; data is the result mod 2^W.
  function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] func, input logic id, input int c);
    exp_t e;
    int   sa, sb, ua, ub, exact, full;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    if (func == FUNC_ADD) begin
      exact = sa + sb;
      full  = ua + ub;
    end else begin
      exact = sa - sb;
      full  = ua - ub;
    end
    e.data    = full[W-1:0];
    e.ovf     = (exact > 32767) || (exact < -32768);
    e.id      = id;
    e.acc_cyc = c;
    e.seen    = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rand_func();
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    return ($urandom_range(0, 1) == 0) ? FUNC_ADD : FUNC_SUB;
  endfunction

  task automatic apply_stimulus(input bit id, input logic v, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [3:0] f);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_func = f;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_func = f;
    end
  endtask

  task automatic accept(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    sb_q.push_back(model_op(a, b, f, id, cyc));
    model_idle = 1'b0;
    model_last = id;
    acc_cyc    = cyc;
    if (id) acc1 = 1'b1; else acc0 = 1'b1;
  endtask

  // One clock: check handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    bit exp0, exp1, grant;
    @(negedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst_at_edge == 1'b0) begin
      check_output("reset_res_valid", 32'(res_valid), 32'd0);
      check_output("reset_res_data", 32'(res_data), 32'd0);
      check_output("reset_res_overflow", 32'(res_overflow), 32'd0);
      check_output("reset_res_id", 32'(res_id), 32'd0);
    end
    if (!reset_n) begin
      check_output("reset_req0_ready", 32'(req0_ready), 32'd0);
      check_output("reset_req1_ready", 32'(req1_ready), 32'd0);
      sb_q.delete();
      model_idle = 1'b1;
      model_last = 1'b1;
    end else begin
      exp0 = 1'b0;
      exp1 = 1'b0;
      if (model_idle && (req0_valid || req1_valid)) begin
        grant = (req0_valid && req1_valid) ? !model_last : req1_valid;
        exp0  = !grant;
        exp1  = grant;
      end
      check_output("req0_ready", 32'(req0_ready), 32'(exp0));
      check_output("req1_ready", 32'(req1_ready), 32'(exp1));
      if (req0_valid && req0_ready) accept(1'b0, req0_a, req0_b, req0_func);
      else if (req1_valid && req1_ready) accept(1'b1, req1_a, req1_b, req1_func);
    end
    @(posedge clk);
    rst_at_edge = reset_n;
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!model_idle || sb_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check_output("idle_timeout", 32'(model_idle), 32'd1);
  endtask

  task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    int n = 0;
    bit got = 1'b0;
    apply_stimulus(id, 1'b1, a, b, f);
    while (!got && n < 10) begin
      tick();
      got = id ? acc1 : acc0;
      n++;
    end
    check_output("grant_timeout", 32'(got), 32'd1);
    apply_stimulus(id, 1'b0, '0, '0, '0);
    wait_idle();
  endtask

  task automatic random_req(input bit id, input bit accepted, input logic cur_valid);
    if (accepted) begin
      apply_stimulus(id, ($urandom_range(0, 2) != 0), rand_operand(), rand_operand(), rand_func());
    end else if (cur_valid) begin
      if ($urandom_range(0, 7) == 0) apply_stimulus(id, 1'b0, rand_operand(), rand_operand(), rand_func());
    end else if ($urandom_range(0, 1) == 0) begin
      apply_stimulus(id, 1'b1, rand_operand(), rand_operand(), rand_func());
    end
  endtask

  // Monitor: compares the presented result with the oldest expected entry every cycle.
  initial begin : monitor
    exp_t it;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && rst_at_edge) begin
        if (res_valid) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_res_valid", 32'(res_valid), 32'd0);
          end else begin
            it = sb_q[0];
            if (!it.seen) begin
              check_output("latency", 32'(cyc - it.acc_cyc), 32'd2);
              it.seen = 1'b1;
              sb_q[0] = it;
            end
            check_output("res_data", 32'(res_data), 32'(it.data));
            check_output("res_overflow", 32'(res_overflow), 32'(it.ovf));
            check_output("res_id", 32'(res_id), 32'(it.id));
            if (res_ready) begin
              void'(sb_q.pop_front());
              model_idle = 1'b1;
            end
          end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].acc_cyc + 2) begin
          check_output("result_timeout", 32'(res_valid), 32'd1);
          void'(sb_q.pop_front());
          model_idle = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int n_acc, prev_cyc, n;
    bit prev_id, got;

    apply_stimulus(1'b0, 1'b1, 16'h1111, 16'h2222, FUNC_ADD);
    apply_stimulus(1'b1, 1'b1, 16'h3333, 16'h4444, FUNC_SUB);
    @(posedge clk);
    rst_at_edge = reset_n;
    #1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_output("first_grant_req0", 32'(acc0), 32'd1);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0);
    wait_idle();

    $display("[TB] directed arithmetic and overflow cases");
    run_op(1'b0, 16'h0003, 16'h0004, FUNC_ADD);
    run_op(1'b1, 16'h7FFF, 16'h0001, FUNC_ADD);
    run_op(1'b1, 16'h8000, 16'h0001, FUNC_SUB);
    run_op(1'b1, 16'hFFFF, 16'h0001, FUNC_ADD);
    run_op(1'b0, 16'h1234, 16'h0034, 4'hA);

    $display("[TB] continuous contention");
    apply_stimulus(1'b0, 1'b1, rand_operand(), rand_operand(), rand_func());
    apply_stimulus(1'b1, 1'b1, rand_operand(), rand_operand(), rand_func());
    res_ready = 1'b1;
    n_acc = 0;
    prev_cyc = 0;
    prev_id = 1'b0;
    for (int i = 0; i < 60 && n_acc < 12; i++) begin
      tick();
      if (acc0 || acc1) begin
        if (n_acc > 0) begin
          check_output("accept_interval", 32'(acc_cyc - prev_cyc), 32'd3);
          check_output("no_repeat_grant", 32'(acc1), 32'(!prev_id));
        end
        prev_cyc = acc_cyc;
        prev_id  = acc1;
        n_acc++;
        apply_stimulus(acc1, 1'b1, rand_operand(), rand_operand(), rand_func());
      end
    end
    check_output("contention_accepts", 32'(n_acc), 32'd12);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0);
    wait_idle();

    $display("[TB] result backpressure");
    res_ready = 1'b0;
    apply_stimulus(1'b0, 1'b1, 16'h8001, 16'h7FFF, FUNC_SUB);
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      tick();
      got = acc0;
      n++;
    end
    check_output("bp_grant_timeout", 32'(got), 32'd1);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b1, 16'h0100, 16'h0001, FUNC_ADD);
    for (int i = 0; i < 6; i++) tick();
    res_ready = 1'b1;
    tick();
    tick();
    check_output("grant_after_release", 32'(acc1), 32'd1);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0);
    wait_idle();

    $display("[TB] reset during execution");
    run_op(1'b0, 16'h0010, 16'h0020, FUNC_ADD);
    apply_stimulus(1'b0, 1'b1, 16'h0005, 16'h0006, FUNC_ADD);
    apply_stimulus(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, FUNC_ADD);
    tick();
    check_output("tie_goes_to_req1", 32'(acc1), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_output("tie_after_reset_req0", 32'(acc0), 32'd1);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0);
    wait_idle();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      random_req(1'b0, acc0, req0_valid);
      random_req(1'b1, acc1, req1_valid);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, '0, '0, '0);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0);
    res_ready = 1'b1;
    wait_idle();
    check_output("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
